game_flow_ctrl: RTL and testbench

//  Sequencer for the falling-platform position datapath. Debounces the player buttons.

---
 rtl/game_pkg.sv | 30 +++
 rtl/game_flow_ctrl_debounce.sv | 56 +++++
 rtl/game_flow_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the falling-platform game sequencer.
// Imported by the flow controller and its button debouncers.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DROP  = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [1:0]  DIR_LEFT  = 2'b10;
    localparam logic [1:0]  DIR_RIGHT = 2'b01;
    localparam logic [1:0]  DIR_NONE  = 2'b00;

    localparam logic [11:0] LAND_Y    = 12'd379;
    localparam int          SCREEN_W  = 640;
    localparam int          PLAT_W    = 100;

    // Both or neither pressed means hold.
    function automatic logic [1:0] steer(input logic l, input logic r);
        logic [1:0] d;
        d = DIR_NONE;
        if (l && !r) d = DIR_LEFT;
        if (r && !l) d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, equal-sample debounce counter,
// registered debounced level and one-cycle rising-edge pulse.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff  = r_s2 ^ r_level;
    assign w_done  = w_diff && (r_cnt == CMAX);
    assign o_level = r_level;
    assign o_rise  = r_rise;

    // Bring the raw asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Count differing samples; flip the level on the last one, clear on any match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            if (!w_diff || w_done) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;
            if (w_done) r_level <= r_s2;
            r_rise <= w_done & r_s2;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: frame tick divider, IDLE/DROP/PLAY/PAUSE/OVER FSM,
// datapath control (ena, dir, pos_rst), score and lives.
module game_flow_ctrl #(
    parameter int          TICK_DIV   = 2097152,
    parameter int          DEB_CYCLES = 1000000,
    parameter logic [11:0] LAND_Y     = game_pkg::LAND_Y,
    parameter int          LIVES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic [11:0] y_pos,
    input  logic        hit,
    output logic        tick,
    output logic [1:0]  dir,
    output logic        ena,
    output logic        pos_rst,
    output logic [2:0]  state,
    output logic [15:0] score,
    output logic [1:0]  lives
);

    import game_pkg::*;

    localparam int            DW         = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE    = DW'(TICK_DIV - 2);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [15:0]   SCORE_MAX  = 16'hFFFF;

    logic w_lvl_left, w_lvl_right, w_lvl_start, w_lvl_pause;
    logic w_rise_left, w_rise_right, w_rise_start, w_rise_pause;
    logic w_unused;

    logic [DW-1:0] r_div;
    logic          r_tick;
    state_t        r_state;
    logic [1:0]    r_lives;
    logic [15:0]   r_score;
    logic          r_pos_rst;
    logic [1:0]    r_dir;
    logic          r_ena;

    state_t        w_state_nxt;
    logic [1:0]    w_lives_nxt;
    logic [15:0]   w_score_nxt;
    logic          w_pos_rst_nxt;
    logic [1:0]    w_dir_nxt;
    logic          w_ena_nxt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk(clk), .rst(rst), .i_btn(btn_left),
        .o_level(w_lvl_left), .o_rise(w_rise_left));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk(clk), .rst(rst), .i_btn(btn_right),
        .o_level(w_lvl_right), .o_rise(w_rise_right));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .i_btn(btn_start),
        .o_level(w_lvl_start), .o_rise(w_rise_start));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk(clk), .rst(rst), .i_btn(btn_pause),
        .o_level(w_lvl_pause), .o_rise(w_rise_pause));

    assign w_unused = ^{w_rise_left, w_rise_right, w_lvl_start, w_lvl_pause};

    assign tick    = r_tick;
    assign dir     = r_dir;
    assign ena     = r_ena;
    assign pos_rst = r_pos_rst;
    assign state   = r_state;
    assign score   = r_score;
    assign lives   = r_lives;

    // Free-running frame divider; tick is registered to line up with the last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_tick <= (r_div == DIV_PRE);
        end
    end

    // Next state, score, lives and datapath controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_lives_nxt   = r_lives;
        w_score_nxt   = r_score;
        w_pos_rst_nxt = 1'b0;
        if (r_state == S_PLAY && r_tick && r_score != SCORE_MAX)
            w_score_nxt = r_score + 16'd1;
        case (r_state)
            S_IDLE:  if (w_rise_start) w_state_nxt = S_DROP;
            S_DROP:  if (y_pos == LAND_Y) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (hit) begin
                    if (r_lives > 2'd1) begin
                        w_lives_nxt = r_lives - 2'd1;
                    end else begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_OVER;
                    end
                end else if (w_rise_pause) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: if (w_rise_pause) w_state_nxt = S_PLAY;
            S_OVER: begin
                if (w_rise_start) begin
                    w_state_nxt   = S_IDLE;
                    w_lives_nxt   = LIVES_INIT;
                    w_score_nxt   = '0;
                    w_pos_rst_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_ena_nxt = !(w_state_nxt == S_DROP || w_state_nxt == S_PLAY);
        w_dir_nxt = (w_state_nxt == S_PLAY) ? steer(w_lvl_left, w_lvl_right)
                                            : DIR_NONE;
    end

    // Register state and every output so they move together one clk after the event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_lives   <= LIVES_INIT;
            r_score   <= '0;
            r_pos_rst <= 1'b0;
            r_dir     <= DIR_NONE;
            r_ena     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_lives   <= w_lives_nxt;
            r_score   <= w_score_nxt;
            r_pos_rst <= w_pos_rst_nxt;
            r_dir     <= w_dir_nxt;
            r_ena     <= w_ena_nxt;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short frame divider and debounce.
// Each task drives one scenario and checks registered outputs 1 ns after the edge.
module tb_game_flow_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_left, btn_right, btn_start, btn_pause;
    logic [11:0] y_pos;
    logic        hit;
    logic        tick, ena, pos_rst;
    logic [1:0]  dir, lives;
    logic [2:0]  state;
    logic [15:0] score;

    int checks;
    int errors;

    game_flow_ctrl #(
        .TICK_DIV(8), .DEB_CYCLES(4), .LAND_Y(12'd379), .LIVES(3)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .btn_pause(btn_pause),
        .y_pos(y_pos), .hit(hit),
        .tick(tick), .dir(dir), .ena(ena), .pos_rst(pos_rst),
        .state(state), .score(score), .lives(lives)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (ena !== 1'b1) begin errors++; $display("FAIL rst_ena got %0b exp 1", ena); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL rst_dir got %b exp 00", dir); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL rst_lives got %0d exp 3", lives); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL rst_score got %0h exp 0", score); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %0b exp 0", tick); end
        checks++; if (pos_rst !== 1'b0) begin errors++; $display("FAIL rst_pos_rst got %0b exp 0", pos_rst); end
        rst = 1'b1;
        step(7);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick got %0b exp 1", tick); end
        step(1);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_width got %0b exp 0", tick); end
    endtask

    task automatic test_start_short;
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(10);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL short_start state got %0d exp 0", state); end
    endtask

    task automatic test_start;
        btn_start = 1'b1;
        step(6);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL start_early state got %0d exp 0", state); end
        step(1);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_drop state got %0d exp 1", state); end
        checks++; if (ena !== 1'b0) begin errors++; $display("FAIL start_drop ena got %0b exp 0", ena); end
        btn_start = 1'b0;
        step(8);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_hold state got %0d exp 1", state); end
    endtask

    task automatic test_drop;
        y_pos = 12'd377;
        step(1);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL drop_377 state got %0d exp 1", state); end
        y_pos = 12'd378;
        step(1);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL drop_378 state got %0d exp 1", state); end
        checks++; if (ena !== 1'b0) begin errors++; $display("FAIL drop_378 ena got %0b exp 0", ena); end
        y_pos = 12'd379;
        step(1);
        y_pos = 12'd0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL drop_land state got %0d exp 2", state); end
        checks++; if (ena !== 1'b0) begin errors++; $display("FAIL drop_land ena got %0b exp 0", ena); end
    endtask

    task automatic test_dir;
        btn_left = 1'b1;
        step(8);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL dir_left got %b exp 10", dir); end
        btn_right = 1'b1;
        step(8);
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL dir_both got %b exp 00", dir); end
        btn_left = 1'b0;
        step(8);
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL dir_right got %b exp 01", dir); end
        btn_right = 1'b0;
        step(8);
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL dir_none got %b exp 00", dir); end
    endtask

    task automatic test_pause;
        btn_left = 1'b1;
        step(8);
        btn_pause = 1'b1;
        step(7);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_enter state got %0d exp 3", state); end
        checks++; if (ena !== 1'b1) begin errors++; $display("FAIL pause_enter ena got %0b exp 1", ena); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL pause_enter dir got %b exp 00", dir); end
        btn_pause = 1'b0;
        step(8);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL pause_hit lives got %0d exp 3", lives); end
        btn_start = 1'b1;
        step(7);
        btn_start = 1'b0;
        step(8);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_start state got %0d exp 3", state); end
        btn_pause = 1'b1;
        step(7);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_exit state got %0d exp 2", state); end
        checks++; if (ena !== 1'b0) begin errors++; $display("FAIL pause_exit ena got %0b exp 0", ena); end
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL pause_exit dir got %b exp 10", dir); end
        btn_pause = 1'b0;
        btn_left  = 1'b0;
        step(8);
    endtask

    task automatic test_hits;
        btn_pause = 1'b1;
        step(6);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL hit_prio state got %0d exp 2", state); end
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL hit_prio lives got %0d exp 2", lives); end
        btn_pause = 1'b0;
        step(8);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        checks++; if (lives !== 2'd1) begin errors++; $display("FAIL hit2 lives got %0d exp 1", lives); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL hit2 state got %0d exp 2", state); end
        step(2);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        checks++; if (lives !== 2'd0) begin errors++; $display("FAIL hit3 lives got %0d exp 0", lives); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL hit3 state got %0d exp 4", state); end
        checks++; if (ena !== 1'b1) begin errors++; $display("FAIL hit3 ena got %0b exp 1", ena); end
        step(2);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        checks++; if (lives !== 2'd0) begin errors++; $display("FAIL over_hit lives got %0d exp 0", lives); end
    endtask

    task automatic test_restart;
        btn_start = 1'b1;
        step(7);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL restart state got %0d exp 0", state); end
        checks++; if (pos_rst !== 1'b1) begin errors++; $display("FAIL restart pos_rst got %0b exp 1", pos_rst); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL restart lives got %0d exp 3", lives); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL restart score got %0h exp 0", score); end
        step(1);
        checks++; if (pos_rst !== 1'b0) begin errors++; $display("FAIL restart pulse got %0b exp 0", pos_rst); end
        btn_start = 1'b0;
        step(8);
    endtask

    task automatic test_saturate;
        int p;
        btn_start = 1'b1;
        step(7);
        btn_start = 1'b0;
        step(8);
        y_pos = 12'd379;
        step(1);
        y_pos = 12'd0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL sat_play state got %0d exp 2", state); end
        p = 0;
        while (tick !== 1'b1 && p < 20) begin
            step(1);
            p++;
        end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL sat_sync tick got %0b exp 1", tick); end
        step(1);
        force dut.r_score = 16'hFFFE;
        #1;
        release dut.r_score;
        p = 1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            p++;
            while (tick !== 1'b1 && p < 30) begin
                step(1);
                p++;
            end
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL sat_tick%0d got %0b exp 1", k, tick); end
            checks++; if (p !== 8) begin errors++; $display("FAIL tick_period%0d got %0d exp 8", k, p); end
            step(1);
            checks++; if (score !== 16'hFFFF) begin errors++; $display("FAIL sat_score%0d got %0h exp ffff", k, score); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL sat_width%0d got %0b exp 0", k, tick); end
            p = 1;
        end
    endtask

    task automatic test_reset_mid_play;
        int n;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        btn_start = 1'b1;
        step(7);
        btn_start = 1'b0;
        step(1);
        y_pos = 12'd379;
        step(1);
        y_pos = 12'd0;
        btn_left = 1'b1;
        step(8);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL mid_dir got %b exp 10", dir); end
        n = 0;
        while (score !== 16'd5 && n < 100) begin
            step(1);
            n++;
        end
        checks++; if (score !== 16'd5) begin errors++; $display("FAIL mid_score got %0d exp 5", score); end
        rst = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_rst state got %0d exp 0", state); end
        checks++; if (ena !== 1'b1) begin errors++; $display("FAIL mid_rst ena got %0b exp 1", ena); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL mid_rst score got %0h exp 0", score); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL mid_rst lives got %0d exp 3", lives); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL mid_rst dir got %b exp 00", dir); end
        btn_left = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        hit       = 1'b0;
        y_pos     = 12'd0;
        step(3);
        test_reset;
        test_start_short;
        test_start;
        test_drop;
        test_dir;
        test_pause;
        test_hits;
        test_restart;
        test_saturate;
        test_reset_mid_play;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
